// File: rtl/memgame_round_if.sv
// memgame_round_if
//   Signal bundle between the memory-game round sequencer and its surroundings
//   (divider tick, start request, pattern store, debounced buttons, LEDs and
//   game-status consumers).
//
//   Handshake semantics: there is no valid/ready back-pressure. tickIn, start,
//   btnValid, winPulse and losePulse are single-cycle strobes, meaningful only in
//   the cycle they are high. btnCode is qualified by btnValid. patternIn is a
//   combinational read of the pattern store at patAddr and is valid in the same
//   cycle as patAddr.
//
//   Modports:
//     master - the environment: drives tickIn, start, patternIn, btnValid, btnCode
//     slave  - the round sequencer: drives patAddr, led, ledOn, busy, level,
//              winPulse, losePulse, dbgState (and score when MEMGAME_SCORE_EN)
//
//   Optional macro MEMGAME_SCORE_EN adds the 8-bit score output.

interface memgame_round_if;
    logic       tickIn;
    logic       start;
    logic [3:0] patternIn;
    logic       btnValid;
    logic [3:0] btnCode;
    logic [3:0] patAddr;
    logic [3:0] led;
    logic       ledOn;
    logic       busy;
    logic [3:0] level;
    logic       winPulse;
    logic       losePulse;
    logic [2:0] dbgState;
`ifdef MEMGAME_SCORE_EN
    logic [7:0] score;
`endif

    modport master (
        output tickIn, start, patternIn, btnValid, btnCode,
        input  patAddr, led, ledOn, busy, level, winPulse, losePulse, dbgState
`ifdef MEMGAME_SCORE_EN
        , input score
`endif
    );

    modport slave (
        input  tickIn, start, patternIn, btnValid, btnCode,
        output patAddr, led, ledOn, busy, level, winPulse, losePulse, dbgState
`ifdef MEMGAME_SCORE_EN
        , output score
`endif
    );
endinterface

// File: rtl/memgame_round_ctrl.sv
// memgame_round_ctrl
//   Round sequencer for the memory game. Plays back the first `level` pattern
//   symbols on the LEDs (SHOW_TICKS lit, GAP_TICKS dark, timed by tickIn), then
//   waits for the player to repeat them, with TIMEOUT_TICKS allowed between
//   presses. A fully correct round advances the level; completing MAX_LEVEL
//   gives a one-cycle winPulse, a wrong press or timeout a one-cycle losePulse.
//
//   Ports:
//     Clk  - rising-edge clock
//     Rst  - synchronous active-low reset
//     bus  - memgame_round_if.slave (see the interface file for signal list)
//            dbgState exposes the current FSM state:
//            0 IDLE, 1 SHOW, 2 GAP, 3 INPUT, 4 WIN, 5 LOSE
//
//   Optional macro MEMGAME_SCORE_EN: adds an 8-bit saturating count of correct
//   presses, cleared by reset and by an accepted start.
//
//   All outputs are registered: one always_comb computes every next value, one
//   always_ff registers them.

module memgame_round_ctrl #(
    parameter int MAX_LEVEL     = 8,
    parameter int SHOW_TICKS    = 5,
    parameter int GAP_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 30
) (
    input logic           Clk,
    input logic           Rst,
    memgame_round_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHOW  = 3'd1,
        S_GAP   = 3'd2,
        S_INPUT = 3'd3,
        S_WIN   = 3'd4,
        S_LOSE  = 3'd5
    } state_t;

    localparam int TCW = $clog2((SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS) + 1;
    localparam int TOW = $clog2(TIMEOUT_TICKS) + 1;
    localparam logic [TCW-1:0] SHOW_LAST = TCW'(SHOW_TICKS - 1);
    localparam logic [TCW-1:0] GAP_LAST  = TCW'(GAP_TICKS - 1);
    localparam logic [TOW-1:0] TO_LAST   = TOW'(TIMEOUT_TICKS - 1);
    localparam logic [3:0]     LVL_MAX   = 4'(MAX_LEVEL);

    state_t         state_q, state_d;
    logic [TCW-1:0] tick_q, tick_d;
    logic [TOW-1:0] to_q, to_d;
    logic [3:0]     addr_q, addr_d;
    logic [3:0]     led_q, led_d;
    logic           ledon_q, ledon_d;
    logic           busy_q, busy_d;
    logic [3:0]     level_q, level_d;
    logic           win_q, win_d;
    logic           lose_q, lose_d;
`ifdef MEMGAME_SCORE_EN
    logic [7:0]     score_q, score_d;
`endif

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        to_d    = to_q;
        addr_d  = addr_q;
        led_d   = led_q;
        ledon_d = ledon_q;
        level_d = level_q;
        win_d   = 1'b0;
        lose_d  = 1'b0;
`ifdef MEMGAME_SCORE_EN
        score_d = score_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    level_d = 4'd1;
                    addr_d  = 4'd0;
                    tick_d  = '0;
                    state_d = S_SHOW;
`ifdef MEMGAME_SCORE_EN
                    score_d = 8'd0;
`endif
                end
            end
            S_SHOW: begin
                // patAddr only becomes valid in the first SHOW cycle, so the
                // symbol is captured then (ledOn is always low on entry).
                if (!ledon_q) begin
                    led_d   = bus.patternIn;
                    ledon_d = 1'b1;
                end
                if (bus.tickIn) begin
                    if (tick_q == SHOW_LAST) begin
                        led_d   = 4'd0;
                        ledon_d = 1'b0;
                        tick_d  = '0;
                        state_d = S_GAP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (bus.tickIn) begin
                    if (tick_q == GAP_LAST) begin
                        tick_d = '0;
                        if (addr_q == level_q - 4'd1) begin
                            addr_d  = 4'd0;
                            to_d    = '0;
                            state_d = S_INPUT;
                        end else begin
                            addr_d  = addr_q + 4'd1;
                            state_d = S_SHOW;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            S_INPUT: begin
                // A press takes priority over a coincident tick; that tick is dropped.
                if (bus.btnValid) begin
                    if (bus.btnCode != bus.patternIn) begin
                        lose_d  = 1'b1;
                        state_d = S_LOSE;
                    end else begin
                        to_d = '0;
`ifdef MEMGAME_SCORE_EN
                        if (score_q != 8'hFF) score_d = score_q + 8'd1;
`endif
                        if (addr_q < level_q - 4'd1) begin
                            addr_d = addr_q + 4'd1;
                        end else if (level_q == LVL_MAX) begin
                            win_d   = 1'b1;
                            state_d = S_WIN;
                        end else begin
                            level_d = level_q + 4'd1;
                            addr_d  = 4'd0;
                            tick_d  = '0;
                            state_d = S_SHOW;
                        end
                    end
                end else if (bus.tickIn) begin
                    if (to_q == TO_LAST) begin
                        lose_d  = 1'b1;
                        state_d = S_LOSE;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
            end
            S_WIN, S_LOSE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            to_q    <= '0;
            addr_q  <= 4'd0;
            led_q   <= 4'd0;
            ledon_q <= 1'b0;
            busy_q  <= 1'b0;
            level_q <= 4'd1;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
`ifdef MEMGAME_SCORE_EN
            score_q <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            to_q    <= to_d;
            addr_q  <= addr_d;
            led_q   <= led_d;
            ledon_q <= ledon_d;
            busy_q  <= busy_d;
            level_q <= level_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
`ifdef MEMGAME_SCORE_EN
            score_q <= score_d;
`endif
        end
    end

    assign bus.patAddr   = addr_q;
    assign bus.led       = led_q;
    assign bus.ledOn     = ledon_q;
    assign bus.busy      = busy_q;
    assign bus.level     = level_q;
    assign bus.winPulse  = win_q;
    assign bus.losePulse = lose_q;
    assign bus.dbgState  = state_q;
`ifdef MEMGAME_SCORE_EN
    assign bus.score     = score_q;
`endif

endmodule

// File: doc/memgame_round_ctrl.md
Name: memgame_round_ctrl

Overview:
- Round sequencer for the memory game.
- Consumes the one-cycle tick pulse produced by the pulse-counting divider chain (one tick per 10 base pulses).
- Plays back the first `level` pattern symbols on the LEDs, then opens a timed window for player button entry.
- Issues win/lose pulses, and advances the level after each fully correct round.

Parameters:
MAX_LEVEL, 8, rounds required to win; legal range 1..15
SHOW_TICKS, 5, ticks each symbol is lit
GAP_TICKS, 2, dark ticks after each symbol
TIMEOUT_TICKS, 30, ticks allowed between button presses before loss

Ports:
Clk  in  1  system clock, rising-edge
Rst  in  1  synchronous, active-low reset
tickIn  in  1  one-cycle timing pulse from the divider
start  in  1  one-cycle request to begin a new game
patternIn  in  4  one-hot symbol at patAddr; combinational, valid in the same cycle
btnValid  in  1  one-cycle debounced press strobe
btnCode  in  4  one-hot button code, qualified by btnValid
patAddr  out  4  pattern index (registered)
led  out  4  symbol being displayed
ledOn  out  1  high while a symbol is lit
busy  out  1  high in every state except IDLE
level  out  4  current round, 1..MAX_LEVEL
winPulse  out  1  one-cycle win indication
losePulse  out  1  one-cycle loss indication

Behaviour:
- Reset (Rst==0 at a rising edge) clears all state and outputs:
  - state=IDLE, patAddr=0, led=0, ledOn=0, busy=0, level=1, winPulse=0, losePulse=0.
  - Internal tick counter and timeout counter cleared.
  - Reset mid-round abandons the round; no win or lose pulse is issued.
- All outputs are registered. The internal tick counter counts only on tickIn==1.
- IDLE:
  - start==1 -> level=1, patAddr=0, tick counter=0, go to SHOW on the next cycle.
  - btnValid is ignored.
- SHOW:
  - led=patternIn latched on entry; ledOn=1.
  - After SHOW_TICKS ticks -> GAP with ledOn=0, led=0, tick counter=0.
- GAP:
  - After GAP_TICKS ticks:
    - If patAddr==level-1 -> patAddr=0, timeout counter=0, go to INPUT.
    - Otherwise patAddr+1, go to SHOW.
- INPUT:
  - The timeout counter increments on each tick.
  - btnValid==1 with btnCode!=patternIn -> LOSE.
  - btnValid==1 with btnCode==patternIn:
    - Timeout counter=0.
    - If patAddr<level-1 -> patAddr+1.
    - Else if level==MAX_LEVEL -> WIN.
    - Else level+1, patAddr=0, tick counter=0, go to SHOW.
  - Timeout counter reaching TIMEOUT_TICKS with no press -> LOSE.
  - Press and tick in the same cycle: the press wins, the timeout counter clears, and that tick is not counted.
- WIN / LOSE:
  - Assert winPulse or losePulse for exactly one cycle, then return to IDLE.
  - level holds its final value until the next start.
- start is ignored while busy==1. tickIn and btnValid arriving in the same cycle as a state entry are honoured by the new state from the following cycle only.
- patAddr never exceeds level-1. level never exceeds MAX_LEVEL. There is no wrap-around.

Optional Feature:
- Macro: MEMGAME_SCORE_EN.
- Defined:
  - Adds output `score[7:0]`, reset to 0 and cleared on an accepted start.
  - Increments by 1 on every correct press; saturates at 255.
  - Holds its value through WIN/LOSE and IDLE.
- Undefined: no score port and no score logic.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then start, with pattern[0]=4'b0001 -> SHOW with led=0001, ledOn=1 for exactly 5 ticks, then ledOn=0 for 2 ticks, then INPUT with patAddr=0.
- Level 1: press btnCode=0001 -> level=2, replay of pattern[0..1], SHOW→GAP sequence twice, then INPUT.
- INPUT: press 4'b0100 when the expected symbol is 4'b0010 -> losePulse high for 1 cycle, busy=0 the next cycle, level held.
- INPUT: no press for 30 ticks -> losePulse on the 30th tick. Repeat with a press on tick 29 coincident with tickIn -> no loss, timeout restarted.
- MAX_LEVEL=2: correct entries through level 2 -> winPulse for 1 cycle, IDLE. start pulsed during SHOW mid-game is ignored.
- Rst low during GAP of level 3 -> all outputs at reset values next cycle, no pulse. With MEMGAME_SCORE_EN: 3 correct presses give score=3, and it clears on start.
